nbbpu_sequencer: RTL



---
 rtl/nbbpu_pkg.sv | 55 +++++
 rtl/nbbpu_sequencer_if.sv | 31 +++
 rtl/nbbpu_decode.sv | 26 ++
 rtl/nbbpu_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nbbpu_pkg.sv
// Shared definitions for the NBBPU control path: opcodes, IR field positions,
// sequencer state encoding and the decoded-instruction record.
package nbbpu_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int X_HI  = 11;
    localparam int X_LO  = 8;
    localparam int Y_HI  = 7;
    localparam int Y_LO  = 4;
    localparam int Z_HI  = 3;
    localparam int Z_LO  = 0;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BNE   = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1101;
    localparam logic [3:0] OP_SETLO = 4'b1110;
    localparam logic [3:0] OP_SETHI = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    typedef struct packed {
        logic is_alu;
        logic is_jump;
        logic is_beq;
        logic is_bne;
        logic is_load;
        logic is_store;
        logic is_setlo;
        logic is_sethi;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/nbbpu_sequencer_if.sv
// Instruction-fetch and data-access request/acknowledge ports of the NBBPU.
interface nbbpu_sequencer_if;
    import nbbpu_pkg::*;

    logic              instr_req;
    logic [DATA_W-1:0] instr_addr;
    logic              instr_ack;
    logic [DATA_W-1:0] instr_data;

    logic              data_req;
    logic              data_we;
    logic [DATA_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output instr_req, instr_addr,
        input  instr_ack, instr_data,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ack, data_rdata
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_ack, instr_data,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ack, data_rdata
    );

endinterface

// File: rtl/nbbpu_decode.sv
// Opcode classifier: maps the IR opcode field to one-hot instruction classes.
module nbbpu_decode
    import nbbpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR: dec.is_alu   = 1'b1;
            OP_JMP:                         dec.is_jump  = 1'b1;
            OP_BEQ:                         dec.is_beq   = 1'b1;
            OP_BNE:                         dec.is_bne   = 1'b1;
            OP_HALT:                        dec.is_halt  = 1'b1;
            OP_LOAD:                        dec.is_load  = 1'b1;
            OP_STORE:                       dec.is_store = 1'b1;
            OP_SETLO:                       dec.is_setlo = 1'b1;
            OP_SETHI:                       dec.is_sethi = 1'b1;
            default:                        dec = '0;
        endcase
    end

endmodule

// File: rtl/nbbpu_sequencer.sv
// Multi-cycle NBBPU control sequencer: fetch, decode, execute, memory access,
// register writeback and PC ownership around the combinational ALU.
//
// state     | meaning
// FETCH     | instr_req held until instr_ack; IR captured on ack
// DECODE    | selects settle; memory address/data captured for load/store
// EXECUTE   | ALU/jump/branch/set-byte write strobe and PC update
// MEM       | data_req held until data_ack; load data captured or store retires
// WRITEBACK | load result written to the register file
// HALT      | stopped until reset
module nbbpu_sequencer
    import nbbpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    nbbpu_sequencer_if.master   mem,
    output logic [DATA_W-1:0]   instruction,
    output logic [DATA_W-1:0]   pc_plus1,
    output logic [SEL_W-1:0]    x_sel,
    output logic [SEL_W-1:0]    y_sel,
    input  logic [DATA_W-1:0]   x_data,
    input  logic [DATA_W-1:0]   y_data,
    output logic [SEL_W-1:0]    z_sel,
    output logic                z_we,
    output logic [1:0]          z_byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic                halted
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              data_we_q, data_we_d;
    logic [DATA_W-1:0] data_addr_q, data_addr_d;
    logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
    logic              instr_req;
    logic              data_req;
    dec_t              dec;

    nbbpu_decode u_decode (
        .opcode (ir_q[OP_HI:OP_LO]),
        .dec    (dec)
    );

    assign instruction = ir_q;
    assign pc_plus1    = pc_q + 16'd1;
    assign x_sel       = ir_q[X_HI:X_LO];
    assign y_sel       = ir_q[Y_HI:Y_LO];
    assign z_sel       = ir_q[Z_HI:Z_LO];
    assign read_data   = read_data_q;
    assign halted      = (state_q == S_HALT);

    assign mem.instr_req  = instr_req;
    assign mem.instr_addr = pc_q;
    assign mem.data_req   = data_req;
    assign mem.data_we    = data_we_q;
    assign mem.data_addr  = data_addr_q;
    assign mem.data_wdata = data_wdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            read_data_q  <= '0;
            data_we_q    <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            read_data_q  <= read_data_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        read_data_d  = read_data_q;
        data_we_d    = data_we_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        instr_req    = 1'b0;
        data_req     = 1'b0;
        z_we         = 1'b0;
        z_byte_en    = 2'b00;

        case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (mem.instr_ack) begin
                    ir_d    = mem.instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.is_load || dec.is_store) begin
                    data_we_d    = dec.is_store;
                    data_addr_d  = x_data;
                    data_wdata_d = y_data;
                    state_d      = S_MEM;
                end else if (dec.is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_plus1;
                if (dec.is_alu) begin
                    z_we      = 1'b1;
                    z_byte_en = 2'b11;
                end else if (dec.is_jump) begin
                    // the ALU routes pc_plus1 onto the write port for the link
                    z_we      = 1'b1;
                    z_byte_en = 2'b11;
                    pc_d      = x_data;
                end else if (dec.is_beq) begin
                    pc_d = (y_data == '0) ? x_data : pc_plus1;
                end else if (dec.is_bne) begin
                    pc_d = (y_data != '0) ? x_data : pc_plus1;
                end else if (dec.is_setlo) begin
                    z_we      = 1'b1;
                    z_byte_en = 2'b01;
                end else if (dec.is_sethi) begin
                    z_we      = 1'b1;
                    z_byte_en = 2'b10;
                end
            end
            S_MEM: begin
                data_req = 1'b1;
                if (mem.data_ack) begin
                    if (data_we_q) begin
                        pc_d    = pc_plus1;
                        state_d = S_FETCH;
                    end else begin
                        read_data_d = mem.data_rdata;
                        state_d     = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                z_we      = 1'b1;
                z_byte_en = 2'b11;
                pc_d      = pc_plus1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // requests must fall in the very cycle reset is asserted
        if (reset) begin
            instr_req = 1'b0;
            data_req  = 1'b0;
        end
    end

endmodule
